// File: rtl/sp_ram_arbiter.sv
// Two-port valid/ready arbiter in front of one single-port RAM with a 1-cycle read.
// Define RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sp_ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      req_ready,
    output logic [1:0]      rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_qout
);

    logic [1:0]    gnt;
    logic          gnt_id;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_id_q, rd_id_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef RR_ARB_EN
    logic last_gnt_q, last_gnt_d;

    // On contention the port that was not granted last time wins.
    always_comb begin
        gnt = 2'b00;
        if (&req_valid) begin
            gnt = last_gnt_q ? 2'b01 : 2'b10;
        end else begin
            gnt = req_valid;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (|gnt) begin
            last_gnt_d = gnt_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (req_valid[0]) begin
            gnt = 2'b01;
        end else if (req_valid[1]) begin
            gnt = 2'b10;
        end
    end
`endif

    assign gnt_id    = gnt[1];
    assign req_ready = gnt;

    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_din  = '0;
        if (|gnt) begin
            mem_addr = req_addr[gnt_id*AW +: AW];
            mem_we   = req_we[gnt_id];
            mem_din  = req_wdata[gnt_id*DW +: DW];
        end
    end

    always_comb begin
        rd_pend_d   = (|gnt) && !mem_we;
        rd_id_d     = rd_pend_d ? gnt_id : rd_id_q;
        rsp_rdata_d = rd_pend_q ? mem_qout : rsp_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q   <= 1'b0;
            rd_id_q     <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // RAM output is live the cycle after the grant; otherwise replay the last value.
    always_comb begin
        rsp_valid = 2'b00;
        rsp_rdata = rsp_rdata_q;
        if (rd_pend_q) begin
            rsp_valid = rd_id_q ? 2'b10 : 2'b01;
            rsp_rdata = mem_qout;
        end
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural single-port RAM.
module tb_sp_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_qout;

    logic [7:0]  ram [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_qout <= ram[mem_addr];
    end

    sp_ram_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_din(mem_din), .mem_qout(mem_qout)
    );

    typedef struct {
        logic [1:0] valid;
        logic [1:0] we;
        logic [7:0] a0, a1, d0, d1;
        logic [1:0] ready;
        logic [7:0] maddr;
        logic       mwe;
        logic [7:0] mdin;
        logic [1:0] rsp;
        logic [7:0] rdata;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    initial begin
        // valid we a0 a1 d0 d1 | ready maddr mwe mdin | rsp rdata (after edge)
        vec[0] = '{2'b01, 2'b01, 8'h01, 8'h00, 8'h10, 8'h00, 2'b01, 8'h01, 1'b1, 8'h10, 2'b00, 8'h00};
        vec[1] = '{2'b01, 2'b01, 8'h03, 8'h00, 8'h30, 8'h00, 2'b01, 8'h03, 1'b1, 8'h30, 2'b00, 8'h00};
        vec[2] = '{2'b10, 2'b00, 8'h00, 8'h01, 8'h00, 8'h00, 2'b10, 8'h01, 1'b0, 8'h00, 2'b10, 8'h10};
        vec[3] = '{2'b10, 2'b00, 8'h00, 8'h03, 8'h00, 8'h00, 2'b10, 8'h03, 1'b0, 8'h00, 2'b10, 8'h30};
        vec[4] = '{2'b00, 2'b00, 8'h55, 8'h66, 8'h77, 8'h88, 2'b00, 8'h00, 1'b0, 8'h00, 2'b00, 8'h30};
        vec[5] = '{2'b01, 2'b01, 8'h0A, 8'h00, 8'hA0, 8'h00, 2'b01, 8'h0A, 1'b1, 8'hA0, 2'b00, 8'h30};
        vec[6] = '{2'b10, 2'b00, 8'h00, 8'h0A, 8'h00, 8'h00, 2'b10, 8'h0A, 1'b0, 8'h00, 2'b10, 8'hA0};
        vec[7] = '{2'b01, 2'b00, 8'h0A, 8'h00, 8'h00, 8'h00, 2'b01, 8'h0A, 1'b0, 8'h00, 2'b01, 8'hA0};
        vec[8] = '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 8'h00, 2'b00, 8'hA0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("reset_ready", 32'(req_ready), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rsp", i - 1), 32'(rsp_valid),
                32'(i == 0 ? 2'b00 : vec[i-1].rsp));
            chk($sformatf("v%0d_rdata", i - 1), 32'(rsp_rdata),
                32'(i == 0 ? 8'h00 : vec[i-1].rdata));
            drive(vec[i].valid, vec[i].we, vec[i].a0, vec[i].a1,
                  vec[i].d0, vec[i].d1);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vec[i].ready));
            chk($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vec[i].maddr));
            chk($sformatf("v%0d_mwe", i), 32'(mem_we), 32'(vec[i].mwe));
            chk($sformatf("v%0d_mdin", i), 32'(mem_din), 32'(vec[i].mdin));
        end
        @(posedge clk);
        #1;
        chk("v8_rsp", 32'(rsp_valid), 32'(vec[8].rsp));
        chk("v8_rdata", 32'(rsp_rdata), 32'(vec[8].rdata));

        // Read granted, then reset pulsed before the response is consumed.
        drive(2'b10, 2'b00, 8'h00, 8'h03, 8'h00, 8'h00);
        #1;
        chk("rstrd_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        #2;
        chk("rstrd_rsp", 32'(rsp_valid), 32'h0);
        chk("rstrd_rdata", 32'(rsp_rdata), 32'h0);
        chk("rstrd_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rstrd_idle%0d", i), 32'(rsp_valid), 32'h0);
        end

        // RAM contents survive the reset.
        drive(2'b01, 2'b00, 8'h03, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        chk("post_rst_rsp", 32'(rsp_valid), 32'h1);
        chk("post_rst_rdata", 32'(rsp_rdata), 32'h30);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);

        // Contention from a fresh reset: port 0 wins first.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, 2'b00, 8'h01, 8'h03, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            logic [1:0] eg;
`ifdef RR_ARB_EN
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            eg = 2'b01;
`endif
            #1;
            chk($sformatf("cont%0d_ready", i), 32'(req_ready), 32'(eg));
            @(posedge clk);
            #1;
            chk($sformatf("cont%0d_rsp", i), 32'(rsp_valid), 32'(eg));
            chk($sformatf("cont%0d_rdata", i), 32'(rsp_rdata),
                32'(eg == 2'b01 ? 8'h10 : 8'h30));
        end
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        chk("cont_end_rsp", 32'(rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
